multicycle_memory: RTL
======================

MULTICYCLE_MEMORY -- requirements
Module: multicycle_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 16-bit words; power of two.
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to mem_ready; legal range 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port readM  input  1  read request.
REQ-006 SHALL have port writeM  input  1  write request.
REQ-007 SHALL have port address  input  16  word address.
REQ-008 SHALL have port data  inout  16  shared bus: CPU drives write data, memory drives read data.
REQ-009 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port req_err  output  1  one-cycle pulse on illegal request.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 IDLE: at a posedge with readM or writeM high, SHALL latch the address, the operation and, for writes, data; load counter with LATENCY-1; go to BUSY, or to DONE directly when LATENCY=1.
REQ-013 BUSY: SHALL decrement the counter each cycle and go to DONE when it reaches 0; readM, writeM, address and data SHALL be ignored.
REQ-014 DONE: mem_ready SHALL be 1 for exactly this cycle; next state SHALL be IDLE unconditionally, so back-to-back accesses are separated by at least one IDLE cycle.
REQ-015 Read: memory SHALL drive data with mem[latched address] only during DONE; otherwise data SHALL be high-Z.
REQ-016 Write: the array SHALL update at the posedge ending DONE using the data latched at acceptance; data SHALL remain high-Z throughout.
REQ-017 Address SHALL wrap modulo DEPTH, using the low log2(DEPTH) bits only.
REQ-018 When readM and writeM are both high at acceptance, SHALL perform a read only, discard the write and pulse req_err in the acceptance cycle.
REQ-019 Request-to-ready latency SHALL be exactly LATENCY cycles: mem_ready is high in the LATENCY-th cycle after the acceptance edge.

Reset
REQ-020 When reset_n is low at a posedge, SHALL set state to IDLE, clear the counter and latched request, and set mem_ready=0 and req_err=0; data SHALL be high-Z.
REQ-021 Reset mid-operation SHALL abort the access; a pending write SHALL NOT modify the array.
REQ-022 Array contents SHALL be preserved across reset.

Configuration
REQ-023 Macro MEM_WAIT_EN: when defined, SHALL behave per REQ-011..REQ-019.
REQ-024 When MEM_WAIT_EN is undefined: no FSM; mem_ready tied 1; data SHALL be driven combinationally with mem[address] while readM=1 and writeM=0; a write SHALL commit at the posedge where writeM=1 and readM=0; both high SHALL read and pulse req_err for one cycle.

Structure
REQ-025 Shared package mem_pkg SHALL hold WORD_SIZE=16, the state enum (IDLE/BUSY/DONE) and the default LATENCY.
REQ-026 Storage SHALL be a sub-module mem_array: synchronous write, asynchronous read, DEPTH x 16.

Verification
REQ-027 With MEM_WAIT_EN and LATENCY=4: write 0xBEEF to 0x0010. mem_ready SHALL pulse 4 cycles after acceptance, and data SHALL stay high-Z.
REQ-028 Read 0x0010 after REQ-027: data SHALL be 0xBEEF in the mem_ready cycle and high-Z before and after it.
REQ-029 Read at address 0x0110 with DEPTH=256: SHALL return the contents of word 0x10 (0xBEEF).
REQ-030 readM=writeM=1, address 0x0020, data 0x1234: req_err SHALL pulse in the acceptance cycle, the old value at 0x20 SHALL be returned, and the array SHALL be unchanged.
REQ-031 Write 0x5555 to 0x0030 with reset_n pulsed low in BUSY: state SHALL be IDLE and mem_ready SHALL be 0 after reset, and a subsequent read of 0x30 SHALL return the prior value.
REQ-032 MEM_WAIT_EN undefined: write 0x00AA at 0x0005, then read: data SHALL be 0x00AA in the same cycle, with mem_ready constantly 1.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the multicycle memory slice: data word width, the
// default access latency and the access-controller state encoding.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int DEFAULT_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH x WORD_SIZE storage: synchronous write, asynchronous (combinational)
// read.
//
// Ports:
//   clk    - rising-edge clock for the write port
//   we     - write enable, array updates at the rising edge
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address
//   rdata  - read data, follows raddr combinationally
// -----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_SIZE-1:0]     wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_SIZE-1:0]     rdata
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; its contents must survive reset
    // and clearing it would also prevent mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/multicycle_memory.sv
// -----------------------------------------------------------------------------
// multicycle_memory
// Word-addressed memory behind a shared bidirectional data bus.
//
// Build option: macro MEM_WAIT_EN
//   defined   - accesses go through an IDLE/BUSY/DONE controller; mem_ready
//               pulses in the LATENCY-th cycle after the acceptance edge. Read
//               data is driven onto the bus only during DONE; writes commit at
//               the edge that ends DONE.
//   undefined - zero-wait memory: mem_ready is tied high, reads drive the bus
//               combinationally, writes commit at the edge they are presented.
// In both builds readM and writeM together perform a read only, and req_err
// is high for the cycle following the edge that sampled the illegal request.
//
// Ports:
//   clk       - rising-edge clock
//   reset_n   - synchronous active-low reset (array contents are preserved)
//   readM     - read request
//   writeM    - write request
//   address   - word address, wraps modulo DEPTH
//   data      - shared bus: CPU drives write data, memory drives read data
//   mem_ready - completion pulse
//   req_err   - illegal request (read and write together) pulse
// -----------------------------------------------------------------------------
module multicycle_memory
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 mem_ready,
    output logic                 req_err
);

    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("multicycle_memory: LATENCY must be in 1..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("multicycle_memory: DEPTH must be a power of two");
    end

    // Only the low AW address bits select a word; the rest wrap away.
    if (AW < WORD_SIZE) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[WORD_SIZE-1:AW];
    end

    logic                 we;
    logic [AW-1:0]        waddr;
    logic [AW-1:0]        raddr;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] rdata;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef MEM_WAIT_EN

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e               state_q,     state_d;
    logic [3:0]           cnt_q,       cnt_d;
    logic                 op_read_q,   op_read_d;
    logic                 op_write_q,  op_write_d;
    logic [AW-1:0]        addr_q,      addr_d;
    logic [WORD_SIZE-1:0] wdata_q,     wdata_d;
    logic                 mem_ready_q, mem_ready_d;
    logic                 req_err_q,   req_err_d;
    logic                 rd_oe_q,     rd_oe_d;

    // Outputs are registered: mem_ready and the read-bus enable are raised on
    // the edge that enters DONE, so they are high for exactly the DONE cycle.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_read_d   = op_read_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_ready_d = 1'b0;
        req_err_d   = 1'b0;
        rd_oe_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (readM || writeM) begin
                    addr_d     = address[AW-1:0];
                    op_read_d  = readM;
                    op_write_d = writeM && !readM;
                    if (writeM && !readM) begin
                        wdata_d = data;
                    end
                    req_err_d  = readM && writeM;
                    cnt_d      = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d     = DONE;
                        mem_ready_d = 1'b1;
                        rd_oe_d     = readM;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Leaving on a count of 1 makes DONE the LATENCY-th cycle
                // after acceptance; the counter lands on 0 as DONE begins.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = DONE;
                    mem_ready_d = 1'b1;
                    rd_oe_d     = op_read_q;
                end
            end
            DONE: begin
                state_d    = IDLE;
                op_read_d  = 1'b0;
                op_write_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_read_q   <= 1'b0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_ready_q <= 1'b0;
            req_err_q   <= 1'b0;
            rd_oe_q     <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_read_q   <= op_read_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_ready_q <= mem_ready_d;
            req_err_q   <= req_err_d;
            rd_oe_q     <= rd_oe_d;
        end
    end

    // The write lands on the edge ending DONE; a reset on that edge aborts it.
    assign we        = (state_q == DONE) && op_write_q && reset_n;
    assign waddr     = addr_q;
    assign wdata     = wdata_q;
    assign raddr     = addr_q;
    assign data      = rd_oe_q ? rdata : 'z;
    assign mem_ready = mem_ready_q;
    assign req_err   = req_err_q;

`else

    logic req_err_q, req_err_d;

    always_comb begin
        req_err_d = readM && writeM;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_err_q <= 1'b0;
        end else begin
            req_err_q <= req_err_d;
        end
    end

    // A combined request reads, so the write is only enabled when alone.
    assign we        = writeM && !readM && reset_n;
    assign waddr     = address[AW-1:0];
    assign wdata     = data;
    assign raddr     = address[AW-1:0];
    assign data      = readM ? rdata : 'z;
    assign mem_ready = 1'b1;
    assign req_err   = req_err_q;

`endif

endmodule
